// File: rtl/mult6x6_pkg.sv
// Shared definitions for the 6x6 multiplier datapath and its dot-product consumer.
//   MULT_LAT     : multiplier latency, operands sampled -> sum valid
//   PROD_W       : multiplier sum width
//   dot_result_t : one completed dot product at the default widths
//   sat_inc      : saturating increment, clamped at max_v
package mult6x6_pkg;

  localparam int unsigned MULT_LAT  = 2;
  localparam int unsigned PROD_W    = 12;
  localparam int unsigned ACC_W_DEF = 20;
  localparam int unsigned CNT_W_DEF = 8;

  typedef struct packed {
    logic [ACC_W_DEF-1:0] data;
    logic [CNT_W_DEF-1:0] terms;
    logic                 ovf;
  } dot_result_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dot_result_q2.sv
// Two-entry FIFO of completed dot-product results.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   push, push_data    : enqueue a result
//   pop                : dequeue the head (ignored when empty)
//   head_valid/data    : registered head entry
//   free_slots_c       : number of empty slots (0..2)
module dot_result_q2
  import mult6x6_pkg::*;
#(
  parameter type T = dot_result_t
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       push,
  input  T           push_data,
  input  logic       pop,
  output logic       head_valid,
  output T           head_data,
  output logic [1:0] free_slots_c
);

  logic tail_valid;
  T     tail_data;
  logic pop_ok;

  assign pop_ok       = pop && head_valid;
  assign free_slots_c = 2'd2 - {1'b0, head_valid} - {1'b0, tail_valid};

  // Head is always the oldest entry; a push during a pop refills the freed slot.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
      head_data  <= '0;
      tail_data  <= '0;
    end else if (pop_ok) begin
      if (tail_valid) begin
        head_data  <= tail_data;
        tail_valid <= push;
        if (push) tail_data <= push_data;
      end else begin
        head_valid <= push;
        if (push) head_data <= push_data;
      end
    end else if (push) begin
      if (!head_valid) begin
        head_valid <= 1'b1;
        head_data  <= push_data;
      end else if (!tail_valid) begin
        tail_valid <= 1'b1;
        tail_data  <= push_data;
      end
    end
  end

endmodule

// File: rtl/mult6x6_dot_accum.sv
// Dot-product accumulator behind the fixed-latency 6x6 multiplier.
//   sys_clk, sys_rst_n : clock (shared with multiplier), async active-low reset
//   en                 : multiplier enable; low flushes partial vector and in-flight terms
//   op_valid, op_last  : operand pair presented to multiplier, last term of vector
//   op_ready           : upstream may issue
//   prod               : multiplier sum, aligned with the tag pipe output
//   res_valid/ready    : result handshake
//   res_data/terms/ovf : dot-product sum, term count (saturating), carry-out seen
module mult6x6_dot_accum #(
  parameter int unsigned PROD_W   = mult6x6_pkg::PROD_W,
  parameter int unsigned ACC_W    = mult6x6_pkg::ACC_W_DEF,
  parameter int unsigned CNT_W    = mult6x6_pkg::CNT_W_DEF,
  parameter int unsigned MULT_LAT = mult6x6_pkg::MULT_LAT
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              en,
  input  logic              op_valid,
  input  logic              op_last,
  output logic              op_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [CNT_W-1:0]  res_terms,
  output logic              res_ovf
);

  localparam int unsigned SUM_W   = ACC_W + 1;
  localparam int unsigned IFL_W   = $clog2(MULT_LAT + 1);
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] terms;
    logic             ovf;
  } res_t;

  logic [MULT_LAT-1:0] tag_v;
  logic [MULT_LAT-1:0] tag_l;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_v;
  logic                first;

  logic                issue;
  logic                pv;
  logic                pl;
  logic                res_push;
  logic [SUM_W-1:0]    sum;
  logic [CNT_W-1:0]    cnt_next;
  logic                ovf_next;
  logic [IFL_W-1:0]    inflight_lasts;
  logic [1:0]          q_free;
  res_t                push_res;
  res_t                head_res;

  assign issue    = op_valid && op_ready;
  assign pv       = tag_v[MULT_LAT-1];
  assign pl       = tag_l[MULT_LAT-1];
  assign res_push = en && pv && pl;

  // Next accumulator state; a fresh vector starts from zero.
  always_comb begin
    sum      = (first ? SUM_W'(0) : SUM_W'(acc)) + SUM_W'(prod);
    cnt_next = first ? CNT_W'(1) : CNT_W'(mult6x6_pkg::sat_inc(32'(cnt), CNT_MAX));
    ovf_next = (first ? 1'b0 : ovf_v) | sum[ACC_W];
    push_res = '{data: sum[ACC_W-1:0], terms: cnt_next, ovf: ovf_next};
  end

  // Vector ends still in flight each need a free slot when they land.
  always_comb begin
    inflight_lasts = '0;
    for (int i = 0; i < MULT_LAT; i++) begin
      inflight_lasts = inflight_lasts + IFL_W'(tag_v[i] & tag_l[i]);
    end
  end

  assign op_ready = en && (32'(q_free) > 32'(inflight_lasts));

  // Tag pipe and accumulator; en low drops everything not yet queued.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tag_v <= '0;
      tag_l <= '0;
      acc   <= '0;
      cnt   <= '0;
      ovf_v <= 1'b0;
      first <= 1'b1;
    end else if (!en) begin
      tag_v <= '0;
      tag_l <= '0;
      acc   <= '0;
      cnt   <= '0;
      ovf_v <= 1'b0;
      first <= 1'b1;
    end else begin
      tag_v <= MULT_LAT'({tag_v, issue});
      tag_l <= MULT_LAT'({tag_l, issue && op_last});
      if (pv) begin
        acc   <= sum[ACC_W-1:0];
        cnt   <= cnt_next;
        ovf_v <= ovf_next;
        first <= pl;
      end
    end
  end

  dot_result_q2 #(
    .T (res_t)
  ) u_res_q (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .push         (res_push),
    .push_data    (push_res),
    .pop          (res_ready),
    .head_valid   (res_valid),
    .head_data    (head_res),
    .free_slots_c (q_free)
  );

  assign res_data  = head_res.data;
  assign res_terms = head_res.terms;
  assign res_ovf   = head_res.ovf;

endmodule

// File: tb/tb_mult6x6_dot_accum.sv
// Bench for mult6x6_dot_accum: default, 13-bit accumulator and 2-bit counter
// instances share stimulus; an exact 2-stage multiplier model feeds prod.
module tb_mult6x6_dot_accum;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        en;
  logic        op_valid;
  logic        op_last;
  logic        res_ready;
  logic [5:0]  op_a;
  logic [5:0]  op_b;
  logic [11:0] p1;
  logic [11:0] prod;

  logic        op_ready0, op_ready1, op_ready2;
  logic        res_valid0, res_valid1, res_valid2;
  logic [19:0] res_data0;
  logic [12:0] res_data1;
  logic [19:0] res_data2;
  logic [7:0]  res_terms0, res_terms1;
  logic [1:0]  res_terms2;
  logic        res_ovf0, res_ovf1, res_ovf2;

  int n_pass = 0;
  int n_chk  = 0;
  int ovf_events = 0;

  typedef struct {
    longint d0, t0, o0, d1, t1, o1, d2, t2, o2;
  } exp_t;

  typedef struct {
    int   n;
    int   a[6];
    int   b[6];
    exp_t e;
  } vec_t;

  vec_t tbl[5];
  exp_t eq[$];

  always #5 sys_clk = ~sys_clk;

  // Exact multiplier, 2-cycle latency, cleared by en low.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      p1   <= '0;
      prod <= '0;
    end else if (!en) begin
      p1   <= '0;
      prod <= '0;
    end else begin
      p1   <= {6'b0, op_a} * {6'b0, op_b};
      prod <= p1;
    end
  end

  mult6x6_dot_accum u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .op_valid(op_valid),
    .op_last(op_last), .op_ready(op_ready0), .prod(prod), .res_valid(res_valid0),
    .res_ready(res_ready), .res_data(res_data0), .res_terms(res_terms0), .res_ovf(res_ovf0)
  );

  mult6x6_dot_accum #(.ACC_W(13)) u_dut_a13 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .op_valid(op_valid),
    .op_last(op_last), .op_ready(op_ready1), .prod(prod), .res_valid(res_valid1),
    .res_ready(res_ready), .res_data(res_data1), .res_terms(res_terms1), .res_ovf(res_ovf1)
  );

  mult6x6_dot_accum #(.CNT_W(2)) u_dut_c2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .op_valid(op_valid),
    .op_last(op_last), .op_ready(op_ready2), .prod(prod), .res_valid(res_valid2),
    .res_ready(res_ready), .res_data(res_data2), .res_terms(res_terms2), .res_ovf(res_ovf2)
  );

  // A completed vector must never land in a full queue.
  always @(negedge sys_clk) begin
    if (sys_rst_n && u_dut.res_push && (u_dut.q_free == 2'd0)) begin
      ovf_events++;
      $display("FAIL queue_push_when_full at %0t: free=%0d required>0", $time, u_dut.q_free);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: dot product from plain integer arithmetic at each instance's widths.
  function automatic exp_t model(input longint total, input int n);
    exp_t r;
    r.d0 = total % (64'd1 << 20); r.o0 = (total >= (64'd1 << 20)) ? 1 : 0;
    r.t0 = (n > 255) ? 255 : n;
    r.d1 = total % 8192;          r.o1 = (total >= 8192) ? 1 : 0;
    r.t1 = r.t0;
    r.d2 = r.d0;                  r.o2 = r.o0;
    r.t2 = (n > 3) ? 3 : n;
    return r;
  endfunction

  task automatic chk_res(input string tag, input exp_t e);
    chk({tag, "_valid0"}, res_valid0, 1);
    chk({tag, "_data0"},  res_data0,  e.d0);
    chk({tag, "_terms0"}, res_terms0, e.t0);
    chk({tag, "_ovf0"},   res_ovf0,   e.o0);
    chk({tag, "_valid1"}, res_valid1, 1);
    chk({tag, "_data1"},  res_data1,  e.d1);
    chk({tag, "_terms1"}, res_terms1, e.t1);
    chk({tag, "_ovf1"},   res_ovf1,   e.o1);
    chk({tag, "_valid2"}, res_valid2, 1);
    chk({tag, "_data2"},  res_data2,  e.d2);
    chk({tag, "_terms2"}, res_terms2, e.t2);
    chk({tag, "_ovf2"},   res_ovf2,   e.o2);
  endtask

  // Present one pair and hold it until accepted; returns just after the issue edge.
  task automatic issue_term(input int a, input int b, input bit last, inout int stalls);
    op_valid = 1'b1;
    op_a     = 6'(a);
    op_b     = 6'(b);
    op_last  = last;
    for (int k = 0; k <= 200; k++) begin
      @(negedge sys_clk);
      if (op_ready0) break;
      stalls++;
      if (k == 200) chk("issue_timeout", 0, 1);
    end
    @(posedge sys_clk); #1;
    op_valid = 1'b0;
    op_last  = 1'b0;
  endtask

  // Count posedges until res_valid is seen at a negedge.
  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 30) begin
      @(posedge sys_clk);
      lat++;
      @(negedge sys_clk);
      if (res_valid0) break;
    end
  endtask

  task automatic pop_one(input string tag, input longint d, input longint t);
    res_ready = 1'b1;
    @(negedge sys_clk);
    chk({tag, "_valid"}, res_valid0, 1);
    chk({tag, "_data"},  res_data0,  d);
    chk({tag, "_terms"}, res_terms0, t);
    @(posedge sys_clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    int stalls;
    int lat;
    int seen;
    bit chk_done;
    int n_vec;

    sys_rst_n = 1'b0; en = 1'b1; op_valid = 1'b0; op_last = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b0;

    tbl[0].n = 3; tbl[0].a = '{3, 63, 1, 0, 0, 0}; tbl[0].b = '{5, 63, 1, 0, 0, 0};
    tbl[0].e = '{3985, 3, 0, 3985, 3, 0, 3985, 3, 0};
    tbl[1].n = 4; tbl[1].a = '{63, 63, 63, 63, 0, 0}; tbl[1].b = '{63, 63, 63, 63, 0, 0};
    tbl[1].e = '{15876, 4, 0, 7684, 4, 1, 15876, 3, 0};
    tbl[2].n = 5; tbl[2].a = '{1, 1, 1, 1, 1, 0}; tbl[2].b = '{1, 1, 1, 1, 1, 0};
    tbl[2].e = '{5, 5, 0, 5, 5, 0, 5, 3, 0};
    tbl[3].n = 1; tbl[3].a = '{2, 0, 0, 0, 0, 0}; tbl[3].b = '{2, 0, 0, 0, 0, 0};
    tbl[3].e = '{4, 1, 0, 4, 1, 0, 4, 1, 0};
    tbl[4].n = 1; tbl[4].a = '{63, 0, 0, 0, 0, 0}; tbl[4].b = '{63, 0, 0, 0, 0, 0};
    tbl[4].e = '{3969, 1, 0, 3969, 1, 0, 3969, 1, 0};

    #12;
    chk("rst_res_valid", res_valid0, 0);
    chk("rst_res_data",  res_data0,  0);
    chk("rst_res_terms", res_terms0, 0);
    chk("rst_res_ovf",   res_ovf0,   0);
    chk("rst_op_ready",  op_ready0,  1);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // Directed vectors, back-to-back issue with the consumer always ready.
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stalls = 0;
      for (int j = 0; j < tbl[i].n; j++)
        issue_term(tbl[i].a[j], tbl[i].b[j], (j == tbl[i].n - 1), stalls);
      wait_result(lat);
      chk($sformatf("tbl%0d_stalls", i), stalls, 0);
      chk($sformatf("tbl%0d_latency", i), lat, 2);
      chk_res($sformatf("tbl%0d", i), tbl[i].e);
      @(posedge sys_clk); #1;
      @(negedge sys_clk);
      chk($sformatf("tbl%0d_popped", i), res_valid0, 0);
      @(posedge sys_clk); #1;
    end

    // Throttle: consumer stalled, three single-term vectors 10, 20, 30.
    res_ready = 1'b0; stalls = 0;
    issue_term(2, 5, 1'b1, stalls);
    issue_term(4, 5, 1'b1, stalls);
    chk("thr_first_two_no_stall", stalls, 0);
    op_valid = 1'b1; op_a = 6'd5; op_b = 6'd6; op_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      chk($sformatf("thr_ready_low%0d", k), op_ready0, 0);
    end
    chk("thr_ready_low_a13", op_ready1, 0);
    chk("thr_ready_low_c2", op_ready2, 0);
    chk("thr_head_valid", res_valid0, 1);
    chk("thr_head_10", res_data0, 10);
    @(posedge sys_clk); #1;
    res_ready = 1'b1;
    @(negedge sys_clk);
    chk("thr_ready_while_full", op_ready0, 0);
    @(posedge sys_clk); #1;
    res_ready = 1'b0;
    @(negedge sys_clk);
    chk("thr_ready_after_pop", op_ready0, 1);
    chk("thr_head_20", res_data0, 20);
    @(posedge sys_clk); #1;
    op_valid = 1'b0; op_last = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    pop_one("thr_second", 20, 1);
    pop_one("thr_third", 30, 1);
    @(negedge sys_clk);
    chk("thr_drained", res_valid0, 0);
    @(posedge sys_clk); #1;

    // en low for one cycle with two terms in flight and one result queued.
    issue_term(2, 5, 1'b1, stalls);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("en_q_valid", res_valid0, 1);
    issue_term(3, 3, 1'b0, stalls);
    issue_term(4, 4, 1'b0, stalls);
    en = 1'b0;
    @(negedge sys_clk);
    chk("en_low_ready", op_ready0, 0);
    chk("en_low_q_valid", res_valid0, 1);
    @(posedge sys_clk); #1;
    en = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
    pop_one("en_kept", 10, 1);
    @(negedge sys_clk);
    chk("en_no_partial", res_valid0, 0);
    @(posedge sys_clk); #1;
    res_ready = 1'b1;
    issue_term(2, 2, 1'b1, stalls);
    wait_result(lat);
    chk("en_next_data", res_data0, 4);
    chk("en_next_terms", res_terms0, 1);
    @(posedge sys_clk); #1;

    // Asynchronous reset mid-vector with a result waiting.
    res_ready = 1'b0;
    issue_term(1, 1, 1'b1, stalls);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("arst_pre_valid", res_valid0, 1);
    issue_term(7, 7, 1'b0, stalls);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_valid", res_valid0, 0);
    chk("arst_data",  res_data0,  0);
    chk("arst_terms", res_terms0, 0);
    chk("arst_ovf",   res_ovf0,   0);
    chk("arst_ready", op_ready0,  1);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    res_ready = 1'b1;
    issue_term(2, 2, 1'b1, stalls);
    wait_result(lat);
    chk("arst_next_data", res_data0, 4);
    chk("arst_next_terms", res_terms0, 1);
    @(posedge sys_clk); #1;

    // Random vectors against the arithmetic model with a random consumer.
    n_vec = 40; seen = 0; chk_done = 1'b0;
    fork
      begin
        for (int v = 0; v < n_vec; v++) begin
          int n;
          int ra[8];
          int rb[8];
          longint total;
          n = int'($urandom_range(1, 8));
          total = 0;
          for (int j = 0; j < n; j++) begin
            ra[j] = int'($urandom_range(0, 63));
            rb[j] = int'($urandom_range(0, 63));
            total += longint'(ra[j] * rb[j]);
          end
          eq.push_back(model(total, n));
          for (int j = 0; j < n; j++) issue_term(ra[j], rb[j], (j == n - 1), stalls);
          repeat (int'($urandom_range(0, 2))) @(posedge sys_clk);
          #1;
        end
      end
      begin
        while (!chk_done) begin
          @(posedge sys_clk); #2;
          res_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        int guard;
        exp_t e;
        guard = 0;
        while (seen < n_vec && guard < 5000) begin
          @(negedge sys_clk);
          guard++;
          if (res_valid0 && res_ready) begin
            if (eq.size() == 0) begin
              chk("rand_unexpected_result", 1, 0);
            end else begin
              e = eq.pop_front();
              chk_res($sformatf("rand%0d", seen), e);
            end
            seen++;
          end
        end
        chk("rand_results_seen", seen, n_vec);
        chk_done = 1'b1;
      end
    join
    chk("rand_queue_empty", eq.size(), 0);
    chk("queue_push_when_full_events", ovf_events, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
